// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, the IF/ID entry layout and
// the NOP encoding used whenever the IF/ID boundary carries no instruction.
package pipeline_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  // One IF/ID boundary entry: fetched word plus the address following it.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc_plus4;
  } if_id_entry_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: redirect/stall control in, instruction memory port and
// IF/ID head out. master = fetch unit, slave = memory/decode side.
interface fetch_unit_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               stall;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc_plus4;
  logic [CW-1:0]      queue_count;

  modport master (
    input  branch_taken, branch_target, stall, imem_data,
    output imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, queue_count
  );

  modport slave (
    output branch_taken, branch_target, stall, imem_data,
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, queue_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO between fetch and decode. Flush beats push and pop; the
// head reads as zero when empty. Callers never push when full or pop when
// empty.
module fetch_queue #(
  parameter  int ENTRY_W = 64,
  parameter  int DEPTH   = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] head,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  // Pointer and occupancy control; reset or flush empties the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; data is not reset, occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC mux, fetch queue control.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/redirect
// counters as extra ports.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                INSTR_W     = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_redirects
`endif
);

  localparam int CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_p0;
  logic [ADDR_W-1:0]  pc_plus4_p0;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               full;
  logic               push;
  logic               pop;
  logic [CW-1:0]      count_p1;
  logic [ENTRY_W-1:0] head_p1;

  // p0: PC and fetch request. PC arithmetic wraps modulo 2^ADDR_W.
  assign pc_plus4_p0 = pc_p0 + ADDR_W'(4);
  assign redirect_pc = bus.branch_target & ~ADDR_W'(3);
  // Full blocks push even if decode pops the head this cycle.
  assign full        = (count_p1 >= CW'(QUEUE_DEPTH));
  assign push        = !bus.branch_taken && !full;
  assign pop         = bus.if_id_valid && !bus.stall && !bus.branch_taken;
  assign bus.imem_addr = pc_p0;

  // Next-PC mux: reset, then redirect, then sequential advance on push.
  always_ff @(posedge clk) begin
    if (reset)                 pc_p0 <= RESET_PC;
    else if (bus.branch_taken) pc_p0 <= redirect_pc;
    else if (push)             pc_p0 <= pc_plus4_p0;
  end

  fetch_queue #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (bus.branch_taken),
    .wr_data ({bus.imem_data, pc_plus4_p0}),
    .head    (head_p1),
    .count   (count_p1)
  );

  // p1: queue head presented at the IF/ID boundary.
  assign bus.if_id_valid    = (count_p1 != '0);
  assign bus.if_id_instr    = bus.if_id_valid ? head_p1[ENTRY_W-1:ADDR_W] : INSTR_W'(NOP);
  assign bus.if_id_pc_plus4 = bus.if_id_valid ? head_p1[ADDR_W-1:0] : '0;
  assign bus.queue_count    = count_p1;

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for stalled-valid cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (bus.if_id_valid && bus.stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bus.branch_taken && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance for queue/redirect/reset
// behaviour and an 8-bit instance starting at 0xF8 for PC wrap (plus the
// perf counters when FETCH_PERF_CNT_EN is defined).
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset_w;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .QUEUE_DEPTH(4)) bus ();
  fetch_unit_if #(.ADDR_W(8),  .INSTR_W(32), .QUEUE_DEPTH(4)) bus_w ();

  assign bus.imem_data   = 32'h1000_0000 | bus.imem_addr;
  assign bus_w.imem_data = 32'h1000_0000 | {24'h0, bus_w.imem_addr};

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_s, perf_r, perf_s_w, perf_r_w;
`endif

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .QUEUE_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_s),
    .perf_redirects    (perf_r)
`endif
  );

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .QUEUE_DEPTH(4)) dut_w (
    .clk   (clk),
    .reset (reset_w),
    .bus   (bus_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_s_w),
    .perf_redirects    (perf_r_w)
`endif
  );

  // Reset the 32-bit DUT and release it; returns on the negedge just after
  // release, before the first post-reset rising edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.if_id_valid !== 1'b0 || bus.queue_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_state: valid=%0b count=%0d, expected valid=0 count=0", bus.if_id_valid, bus.queue_count);
    end
    n_checks++;
    if (bus.if_id_instr !== 32'h0 || bus.if_id_pc_plus4 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_head: instr=%h pc4=%h, expected 0/0", bus.if_id_instr, bus.if_id_pc_plus4);
    end
    n_checks++;
    if (bus.imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_addr: imem_addr=%h, expected 00000000", bus.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.if_id_valid !== 1'b1 || bus.queue_count !== 3'd1 ||
          bus.if_id_instr !== 32'h1000_0000 + 32'(4*i) || bus.if_id_pc_plus4 !== 32'(4*(i+1))) begin
        n_errors++;
        $display("FAIL stream_%0d: valid=%0b count=%0d instr=%h pc4=%h, expected 1/1/%h/%h", i,
                 bus.if_id_valid, bus.queue_count, bus.if_id_instr, bus.if_id_pc_plus4,
                 32'h1000_0000 + 32'(4*i), 32'(4*(i+1)));
      end
    end
  endtask

  task automatic test_stall();
    int exp_cnt  [6] = '{2, 3, 4, 4, 4, 4};
    int exp_addr [6] = '{8, 12, 16, 16, 16, 16};
    do_reset();
    @(negedge clk);          // head (0x1000_0000, 4), PC = 4
    bus.stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.queue_count !== 3'(exp_cnt[i]) || bus.imem_addr !== 32'(exp_addr[i]) ||
          bus.if_id_pc_plus4 !== 32'd4) begin
        n_errors++;
        $display("FAIL stall_fill_%0d: count=%0d addr=%h pc4=%h, expected %0d/%h/00000004", i,
                 bus.queue_count, bus.imem_addr, bus.if_id_pc_plus4, exp_cnt[i], exp_addr[i]);
      end
    end
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'(8 + 4*i) ||
          bus.if_id_instr !== 32'h1000_0004 + 32'(4*i)) begin
        n_errors++;
        $display("FAIL stall_drain_%0d: valid=%0b instr=%h pc4=%h, expected 1/%h/%h", i,
                 bus.if_id_valid, bus.if_id_instr, bus.if_id_pc_plus4,
                 32'h1000_0004 + 32'(4*i), 32'(8 + 4*i));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    bus.stall = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.queue_count !== 3'd3) begin
      n_errors++;
      $display("FAIL branch_precount: count=%0d, expected 3", bus.queue_count);
    end
    bus.stall = 1'b0;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_0103;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    n_checks++;
    if (bus.if_id_valid !== 1'b0 || bus.queue_count !== 3'd0 || bus.imem_addr !== 32'h100 ||
        bus.if_id_instr !== 32'h0 || bus.if_id_pc_plus4 !== 32'h0) begin
      n_errors++;
      $display("FAIL branch_flush: valid=%0b count=%0d addr=%h instr=%h pc4=%h, expected 0/0/00000100/0/0",
               bus.if_id_valid, bus.queue_count, bus.imem_addr, bus.if_id_instr, bus.if_id_pc_plus4);
    end
    @(negedge clk);
    n_checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_instr !== 32'h1000_0100 || bus.if_id_pc_plus4 !== 32'h104) begin
      n_errors++;
      $display("FAIL branch_target_head: valid=%0b instr=%h pc4=%h, expected 1/10000100/00000104",
               bus.if_id_valid, bus.if_id_instr, bus.if_id_pc_plus4);
    end
  endtask

  task automatic test_branch_stall_full();
    do_reset();
    @(negedge clk);
    bus.stall = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.queue_count !== 3'd4) begin
      n_errors++;
      $display("FAIL full_precount: count=%0d, expected 4", bus.queue_count);
    end
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_2002;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    n_checks++;
    if (bus.queue_count !== 3'd0 || bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h2000) begin
      n_errors++;
      $display("FAIL branch_stall_full: count=%0d valid=%0b addr=%h, expected 0/0/00002000",
               bus.queue_count, bus.if_id_valid, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk);
    bus.stall = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.queue_count !== 3'd3) begin
      n_errors++;
      $display("FAIL midreset_precount: count=%0d, expected 3", bus.queue_count);
    end
    reset = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_0200;
    @(negedge clk);
    reset = 1'b0;
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    n_checks++;
    if (bus.queue_count !== 3'd0 || bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_stall: count=%0d valid=%0b addr=%h, expected 0/0/00000000",
               bus.queue_count, bus.if_id_valid, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [3] = '{8'hF8, 8'hFC, 8'h00};
    @(negedge clk);
    reset_w = 1'b1;
    bus_w.stall = 1'b0;
    bus_w.branch_taken = 1'b0;
    bus_w.branch_target = '0;
    @(negedge clk);
    reset_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (bus_w.imem_addr !== exp_addr[i]) begin
        n_errors++;
        $display("FAIL wrap_addr_%0d: addr=%h, expected %h", i, bus_w.imem_addr, exp_addr[i]);
      end
    end
    n_checks++;
    if (bus_w.if_id_valid !== 1'b1 || bus_w.if_id_instr !== 32'h1000_00FC || bus_w.if_id_pc_plus4 !== 8'h00) begin
      n_errors++;
      $display("FAIL wrap_head: valid=%0b instr=%h pc4=%h, expected 1/100000fc/00",
               bus_w.if_id_valid, bus_w.if_id_instr, bus_w.if_id_pc_plus4);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_s_w !== 32'd0 || perf_r_w !== 32'd0) begin
      n_errors++;
      $display("FAIL perf_reset: stall_cycles=%0d redirects=%0d, expected 0/0", perf_s_w, perf_r_w);
    end
    bus_w.stall = 1'b1;
    repeat (5) @(negedge clk);
    bus_w.stall = 1'b0;
    bus_w.branch_taken = 1'b1;
    bus_w.branch_target = 8'h40;
    repeat (2) @(negedge clk);
    bus_w.branch_taken = 1'b0;
    @(negedge clk);
    n_checks++;
    if (perf_s_w !== 32'd5 || perf_r_w !== 32'd2) begin
      n_errors++;
      $display("FAIL perf_counts: stall_cycles=%0d redirects=%0d, expected 5/2", perf_s_w, perf_r_w);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    reset_w = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus_w.stall = 1'b0;
    bus_w.branch_taken = 1'b0;
    bus_w.branch_target = '0;
    test_reset();
    test_stall();
    test_branch();
    test_branch_stall_full();
    test_reset_mid_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
